uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver: the receive-side counterpart of the team's `uart_tx`, using the same line format. Idle high, one start bit (low), DATA_WIDTH data bits LSB first, one stop bit (high). The block runs directly on sys_clk with a bit-period counter rather than a derived clock. It synchronises the asynchronous serial input, validates the start bit at mid-bit, samples each data bit at its centre and checks the stop bit. Each good word is delivered to the downstream logic as a parallel word with a single-cycle valid strobe.

## Interface
- SYS_CLK_FREQ, 10**6: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- DATA_WIDTH, 8: data bits per frame.
- sys_clk  in  1  system clock; all logic on rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- data_in  in  1  serial line input, asynchronous to sys_clk.
- data_out  out  DATA_WIDTH  last correctly received word.
- data_valid  out  1  one-cycle pulse; data_out holds a new word.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- parity_err  out  1  one-cycle pulse; parity mismatch (see Configuration).
- busy  out  1  high while a frame is being received.

## Operation
- N = SYS_CLK_FREQ / BAUD_RATE, using integer division.
  - N must be >= 4; a compile-time check enforces this.
  - The bit counter is $clog2(N) bits wide and counts 0..N-1.
- Two-flop synchroniser on data_in; both flops reset to 1. rx_s is the second flop; rx_p is rx_s delayed one cycle, also reset to 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP. The counter clears on every state entry.
- IDLE -> START when rx_p==1 and rx_s==0 (falling edge). A line held low never triggers reception.
- START: at cnt==N/2-1, sample rx_s.
  - rx_s==1 (glitch) -> IDLE, with no outputs pulsed.
  - rx_s==0 -> DATA with bit index 0.
- DATA: at cnt==N-1, shift rx_s into the shift register at position bit_index (LSB first) and clear the counter.
  - After bit DATA_WIDTH-1 -> PARITY if enabled, else STOP.
- PARITY: at cnt==N-1, sample the parity bit -> STOP.
- STOP: at cnt==N-1, sample rx_s, then go to IDLE. The FSM leaves STOP at mid-stop-bit, so a following start edge is accepted immediately.
  - rx_s==1 and no parity error -> load data_out and pulse data_valid.
  - rx_s==0 -> pulse frame_err; data_out is unchanged and data_valid stays low.
- busy = (state != IDLE).
- data_valid, frame_err and parity_err are mutually exclusive, except that frame_err and parity_err may pulse together.
- Reset values:
  - data_out 0; data_valid, frame_err, parity_err, busy 0.
  - FSM IDLE; shift register 0.
- areset_n asserted mid-frame aborts immediately to IDLE. No pulses are produced and the partial word is discarded.

## Timing
- E0 is the first sys_clk edge that captures data_in==0 into the first synchroniser flop.
  - rx_s is low after E0+1.
  - START is entered at E0+2.
- Start bit is validated at E0+2+N/2.
- Data bit i is sampled at E0+2+N/2+(i+1)·N.
- Stop bit is sampled at E0+2+N/2+(DATA_WIDTH+1)·N (plus N with parity).
  - data_valid, frame_err and parity_err are registered and are high for exactly the one cycle after that edge.
  - data_out updates on the same edge as data_valid rises.
- Defaults (N=104, 8 bits): data_valid rises at E0+990; E0+1094 with parity.
- There is no backpressure. Downstream must capture data_out while data_valid is high; data_out is stable until the next good frame.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state is compiled in; one even-parity bit is expected between the data and stop bits.
  - Even parity means the XOR of the data bits and the parity bit must equal 0.
  - On mismatch: pulse parity_err and do not assert data_valid or update data_out.
- UART_RX_PARITY_EN undefined:
  - PARITY is absent; the frame is start + data + stop.
  - parity_err is tied to 0.

## Test plan
- Reset, then idle line: data_out=0x00, all pulses 0, busy=0. Hold 2000 cycles with data_in=1 -> no change.
- Default params, send 0xA5 with a correct stop bit:
  - busy rises at E0+2.
  - data_valid pulses at E0+990 with data_out=0xA5; frame_err=0.
  - busy falls on the same edge.
- data_in low for 30 cycles, then high:
  - busy high from E0+2 to E0+54, then returns to IDLE.
  - No data_valid, frame_err or parity_err.
- Send 0x3C with the stop bit driven low:
  - frame_err pulses at E0+990; data_out stays 0xA5.
  - Hold the line low 3000 cycles -> no further reception.
  - Release to high, send 0x0F -> data_out=0x0F.
- Back-to-back 0x00 then 0xFF, each with one stop bit: two data_valid pulses 1040 cycles apart with correct words. Then assert areset_n during bit 3 of a third frame -> busy=0 immediately, no pulse; a following 0x5A is received.
- With UART_RX_PARITY_EN defined:
  - Send 0x07 with parity bit 1 -> data_valid at E0+1094, data_out=0x07.
  - Send 0x07 with parity bit 0 -> parity_err pulse, no data_valid.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: UART receiver running on sys_clk with a bit-period counter.
// Frame: idle high, start bit (low), DATA_WIDTH data bits LSB first,
// optional even-parity bit, one stop bit (high).
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and parity_err).
module uart_rx #(
    parameter int SYS_CLK_FREQ = 10**6,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  sys_clk,
    input  logic                  areset_n,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  busy
);

    localparam int N  = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(N / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    if (N < 4) begin : g_bad_ratio
        $error("uart_rx: SYS_CLK_FREQ / BAUD_RATE must be at least 4");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shreg_q;
    logic                    rx_meta, rx_s, rx_p;
    logic                    shift_en, par_sample, stop_sample;
    logic                    par_bad;

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_p    <= 1'b1;
        end else begin
            rx_meta <= data_in;
            rx_s    <= rx_meta;
            rx_p    <= rx_s;
        end
    end

    // FSM state, bit-period counter and bit index registers.
    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; counter clears whenever a state is (re)entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_en    = 1'b0;
        par_sample  = 1'b0;
        stop_sample = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_p && !rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    shift_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    par_sample = 1'b1;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_q;

    // Captured parity bit, checked against the data at stop-bit time.
    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) par_q <= 1'b0;
        else if (par_sample) par_q <= rx_s;
    end

    assign par_bad = ^{shreg_q, par_q};

    // Parity error strobe, issued together with the stop-bit decision.
    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) parity_err <= 1'b0;
        else parity_err <= stop_sample && par_bad;
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Shift register, delivered word and the valid / framing-error strobes.
    always_ff @(posedge sys_clk or negedge areset_n) begin
        if (!areset_n) begin
            shreg_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (shift_en) shreg_q[idx_q] <= rx_s;
            if (stop_sample) begin
                frame_err <= !rx_s;
                if (rx_s && !par_bad) begin
                    data_out   <= shreg_q;
                    data_valid <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: random and directed frames checked against a
// frame-level reference model (event kind, event cycle, delivered word).
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 9600;
    localparam int W      = 8;
    localparam int N      = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = W + 2 + PAR_BITS;

    logic         sys_clk = 1'b0;
    logic         areset_n = 1'b0;
    logic         data_in = 1'b1;
    logic [W-1:0] data_out;
    logic         data_valid, frame_err, parity_err, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         t;
        int         kind;   // 0 valid, 1 frame error, 2 parity error
        logic [7:0] d;
    } ev_t;

    ev_t  evq[$];
    int   rise_q[$];
    int   fall_q[$];
    logic busy_prev = 1'b0;
    logic [7:0] last_word = 8'h00;

    uart_rx #(
        .SYS_CLK_FREQ(CLK_HZ),
        .BAUD_RATE   (BAUD),
        .DATA_WIDTH  (W)
    ) dut (
        .sys_clk   (sys_clk),
        .areset_n  (areset_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record output events 1 time unit after each edge, stamped with the edge number.
    always @(posedge sys_clk) begin
        #1;
        if (data_valid) evq.push_back('{cyc, 0, data_out});
        if (frame_err)  evq.push_back('{cyc, 1, data_out});
        if (parity_err) evq.push_back('{cyc, 2, data_out});
        if (busy && !busy_prev) rise_q.push_back(cyc);
        if (!busy && busy_prev) fall_q.push_back(cyc);
        busy_prev = busy;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        evq.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    // Drive a level for n clock cycles; always returns 1 unit after an edge.
    task automatic hold(input logic b, input int n);
        data_in = b;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop_b,
                              input logic par_b, output int e0);
        clear_obs();
        e0 = cyc + 1;
        hold(1'b0, N);
        for (int i = 0; i < W; i++) hold(w[i], N);
`ifdef UART_RX_PARITY_EN
        hold(par_b, N);
`else
        if (par_b === 1'bx) hold(1'b1, 0);
`endif
        hold(stop_b, N);
    endtask

    // Reference: decision lands at the middle of the stop bit, i.e. 2 sync
    // cycles + half a bit + (data + parity + start-to-first-data) whole bits.
    task automatic check_frame(input string tag, input logic [7:0] w,
                               input logic stop_b, input logic par_b, input int e0);
        int  t_ev;
        bit  pbad;
        ev_t exp_q[$];
        t_ev = e0 + 2 + N / 2 + (W + 1 + PAR_BITS) * N;
`ifdef UART_RX_PARITY_EN
        pbad = (($countones(w) + int'(par_b)) % 2) != 0;
`else
        pbad = 1'b0;
        if (par_b === 1'bx) pbad = 1'b0;
`endif
        if (stop_b && !pbad) begin
            exp_q.push_back('{t_ev, 0, w});
            last_word = w;
        end else begin
            if (!stop_b) exp_q.push_back('{t_ev, 1, 8'h00});
            if (pbad)    exp_q.push_back('{t_ev, 2, 8'h00});
        end
        chk({tag, "_busy_rise_n"}, rise_q.size(), 1);
        if (rise_q.size() > 0) chk({tag, "_busy_rise"}, rise_q[0], e0 + 2);
        chk({tag, "_busy_fall_n"}, fall_q.size(), 1);
        if (fall_q.size() > 0) chk({tag, "_busy_fall"}, fall_q[0], t_ev);
        chk({tag, "_n_events"}, evq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
            chk({tag, "_ev_kind"}, evq[i].kind, exp_q[i].kind);
            chk({tag, "_ev_time"}, evq[i].t, exp_q[i].t);
            if (exp_q[i].kind == 0) chk({tag, "_word"}, evq[i].d, exp_q[i].d);
        end
        chk({tag, "_data_out"}, data_out, last_word);
    endtask

    function automatic logic even_par(input logic [7:0] w);
        return logic'($countones(w) % 2);
    endfunction

    initial begin
        int e0, e0b, tv0, tv1;
        logic [7:0] w;
        logic stop_b, par_b;

        // Reset and idle line
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_busy", busy, 0);
        areset_n = 1'b1;
        clear_obs();
        hold(1'b1, 2000);
        chk("idle_events", evq.size(), 0);
        chk("idle_busy_rises", rise_q.size(), 0);
        chk("idle_data_out", data_out, 0);

        // Directed 0xA5, good frame
        send_frame(8'hA5, 1'b1, even_par(8'hA5), e0);
        check_frame("a5", 8'hA5, 1'b1, even_par(8'hA5), e0);
        hold(1'b1, 20);

        // Start-bit glitch of 30 cycles
        clear_obs();
        e0 = cyc + 1;
        hold(1'b0, 30);
        hold(1'b1, 200);
        chk("glitch_rise_n", rise_q.size(), 1);
        if (rise_q.size() > 0) chk("glitch_rise", rise_q[0], e0 + 2);
        chk("glitch_fall_n", fall_q.size(), 1);
        if (fall_q.size() > 0) chk("glitch_fall", fall_q[0], e0 + 2 + N / 2);
        chk("glitch_events", evq.size(), 0);

        // Framing error, then stuck-low line, then recovery
        send_frame(8'h3C, 1'b0, even_par(8'h3C), e0);
        check_frame("ferr", 8'h3C, 1'b0, even_par(8'h3C), e0);
        clear_obs();
        hold(1'b0, 3000);
        chk("stuck_events", evq.size(), 0);
        chk("stuck_rises", rise_q.size(), 0);
        hold(1'b1, 10);
        send_frame(8'h0F, 1'b1, even_par(8'h0F), e0);
        check_frame("recov", 8'h0F, 1'b1, even_par(8'h0F), e0);

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1, even_par(8'h00), e0);
        tv0 = (evq.size() > 0) ? evq[0].t : -1;
        check_frame("b2b0", 8'h00, 1'b1, even_par(8'h00), e0);
        send_frame(8'hFF, 1'b1, even_par(8'hFF), e0b);
        tv1 = (evq.size() > 0) ? evq[0].t : -1;
        check_frame("b2b1", 8'hFF, 1'b1, even_par(8'hFF), e0b);
        chk("b2b_spacing", tv1 - tv0, FRAME_BITS * N);

        // Reset during data bit 3 of a third frame
        clear_obs();
        w = 8'hC3;
        hold(1'b0, N);
        for (int i = 0; i < 3; i++) hold(w[i], N);
        hold(w[3], N / 2);
        areset_n = 1'b0;
        #2;
        chk("abort_busy", busy, 0);
        chk("abort_valid", data_valid, 0);
        chk("abort_ferr", frame_err, 0);
        data_in = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        areset_n = 1'b1;
        clear_obs();
        hold(1'b1, 2 * N);
        last_word = 8'h00;
        chk("abort_events", evq.size(), 0);
        chk("abort_data_out", data_out, 0);
        send_frame(8'h5A, 1'b1, even_par(8'h5A), e0);
        check_frame("post_rst", 8'h5A, 1'b1, even_par(8'h5A), e0);

`ifdef UART_RX_PARITY_EN
        // Parity: correct then wrong parity bit for 0x07
        send_frame(8'h07, 1'b1, 1'b1, e0);
        check_frame("par_ok", 8'h07, 1'b1, 1'b1, e0);
        send_frame(8'h07, 1'b1, 1'b0, e0);
        check_frame("par_bad", 8'h07, 1'b1, 1'b0, e0);
`endif

        // Randomised frames with random gaps, stop and parity faults
        for (int k = 0; k < 10; k++) begin
            w      = 8'($urandom);
            stop_b = ($urandom_range(0, 3) != 0);
            par_b  = even_par(w) ^ ($urandom_range(0, 4) == 0);
            send_frame(w, stop_b, par_b, e0);
            check_frame("rand", w, stop_b, par_b, e0);
            hold(1'b1, stop_b ? $urandom_range(0, 20) : $urandom_range(2, 20));
        end

        hold(1'b1, 20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
